// File: rtl/uart_tx_feed_pkg.sv
// Shared types and helpers for the multi-channel UART line feeder.
// Holds the FSM state encoding, a default blank line and a clog2 helper.
package uart_tx_feed_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      CAPT,
      DATA,
      DONE
   } state_e;

   localparam int C_LINE_BYTES = 34;

   // 32 spaces followed by CR LF, first byte sent sits in the top bits
   localparam logic [C_LINE_BYTES*8-1:0] c_line_of_spaces = {{32{8'h20}}, 8'h0D, 8'h0A};

   function automatic int f_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_feed_rr_arb.sv
// Combinational round-robin arbiter: first pending channel at or above the
// pointer, searching upward with wrap, as a one-hot grant and an index.
module uart_feed_rr_arb
   import uart_tx_feed_pkg::*;
#(
   parameter int PARM_NUM_CH = 2,
   parameter int PARM_IDX_W  = (f_clog2(PARM_NUM_CH) < 1) ? 1 : f_clog2(PARM_NUM_CH)
) (
   input  logic [PARM_NUM_CH-1:0] i_pending,
   input  logic [PARM_IDX_W-1:0]  i_ptr,
   output logic [PARM_NUM_CH-1:0] o_grant_oh,
   output logic [PARM_IDX_W-1:0]  o_grant_idx
);

   logic [PARM_IDX_W-1:0] cand_idx [PARM_NUM_CH];
   logic                  found;

   // cand_idx[k] is the channel visited k steps after the pointer
   for (genvar gi = 0; gi < PARM_NUM_CH; gi++) begin : g_cand
      logic [PARM_IDX_W:0] sum;
      assign sum = {1'b0, i_ptr} + (PARM_IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (PARM_IDX_W+1)'(PARM_NUM_CH))
                            ? PARM_IDX_W'(sum - (PARM_IDX_W+1)'(PARM_NUM_CH))
                            : sum[PARM_IDX_W-1:0];
   end

   always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      found       = 1'b0;
      for (int off = 0; off < PARM_NUM_CH; off++) begin
         if (!found && i_pending[cand_idx[off]]) begin
            found                     = 1'b1;
            o_grant_oh[cand_idx[off]] = 1'b1;
            o_grant_idx               = cand_idx[off];
         end
      end
   end

endmodule

// File: rtl/uart_tx_line_feed_mc.sv
// Multi-channel line feeder: edge-triggered requests, round-robin grant, and a
// left-aligned shift register streaming the granted line MSB byte first.
module uart_tx_line_feed_mc
   import uart_tx_feed_pkg::*;
#(
   parameter int PARM_NUM_CH   = 2,
   parameter int PARM_LINE_LEN = 34,
   parameter int PARM_LEN_W    = 6,
   localparam int IDX_W        = (f_clog2(PARM_NUM_CH) < 1) ? 1 : f_clog2(PARM_NUM_CH),
   localparam int LINE_W       = PARM_LINE_LEN * 8
) (
   input  logic                                 i_clk_20mhz,
   input  logic                                 i_rst_20mhz_n,
   input  logic [PARM_NUM_CH-1:0]               i_tx_go,
   input  logic [PARM_NUM_CH*PARM_LINE_LEN*8-1:0] i_dat_ascii_lines,
   input  logic [PARM_NUM_CH*PARM_LEN_W-1:0]    i_dat_lens,
   output logic [7:0]                           o_tx_data,
   output logic                                 o_tx_valid,
   input  logic                                 i_tx_ready,
   output logic                                 o_busy,
   output logic [IDX_W-1:0]                     o_active_ch,
   output logic [PARM_NUM_CH-1:0]               o_line_done,
   output logic [PARM_NUM_CH-1:0]               o_overrun
);

   state_e                  state_q;
   logic [PARM_NUM_CH-1:0]  go_q, pending_q, pending_d, overrun_q, overrun_d, done_q;
   logic [PARM_NUM_CH-1:0]  req, clr, grant_oh;
   logic [IDX_W-1:0]        ptr_q, grant_q, grant_idx, next_ptr;
   logic [LINE_W-1:0]       shift_q, capt_shift;
   logic [PARM_LEN_W-1:0]   cnt_q, capt_len;
   logic                    valid_q;

   logic [LINE_W-1:0]       lines_a [PARM_NUM_CH];
   logic [PARM_LEN_W-1:0]   lens_a  [PARM_NUM_CH];

   for (genvar gi = 0; gi < PARM_NUM_CH; gi++) begin : g_slice
      assign lines_a[gi] = i_dat_ascii_lines[gi*LINE_W +: LINE_W];
      assign lens_a[gi]  = i_dat_lens[gi*PARM_LEN_W +: PARM_LEN_W];
   end

   uart_feed_rr_arb #(
      .PARM_NUM_CH (PARM_NUM_CH),
      .PARM_IDX_W  (IDX_W)
   ) u_arb (
      .i_pending   (pending_q),
      .i_ptr       (ptr_q),
      .o_grant_oh  (grant_oh),
      .o_grant_idx (grant_idx)
   );

   // A request landing on the cycle its bit is granted re-arms it rather than merging
   always_comb begin
      req       = i_tx_go & ~go_q;
      clr       = (state_q == ARB) ? grant_oh : '0;
      pending_d = (pending_q & ~clr) | req;
      overrun_d = req & pending_q & ~clr;
      next_ptr  = (grant_idx == IDX_W'(PARM_NUM_CH-1)) ? '0 : grant_idx + IDX_W'(1);
      capt_len  = (lens_a[grant_q] > PARM_LEN_W'(PARM_LINE_LEN))
                  ? PARM_LEN_W'(PARM_LINE_LEN) : lens_a[grant_q];
      capt_shift = lines_a[grant_q] << (8 * (PARM_LINE_LEN - int'(capt_len)));
   end

   always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
      if (!i_rst_20mhz_n) begin
         state_q   <= IDLE;
         go_q      <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         done_q    <= '0;
         ptr_q     <= '0;
         grant_q   <= '0;
         shift_q   <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         go_q      <= i_tx_go;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         done_q    <= '0;
         unique case (state_q)
            IDLE: if (|pending_q) state_q <= ARB;
            ARB: begin
               grant_q <= grant_idx;
               ptr_q   <= next_ptr;
               state_q <= CAPT;
            end
            CAPT: begin
               shift_q <= capt_shift;
               cnt_q   <= capt_len;
               if (capt_len == '0) begin
                  done_q[grant_q] <= 1'b1;
                  state_q         <= DONE;
               end else begin
                  valid_q <= 1'b1;
                  state_q <= DATA;
               end
            end
            DATA: if (i_tx_ready) begin
               shift_q <= {shift_q[LINE_W-9:0], 8'h00};
               cnt_q   <= cnt_q - PARM_LEN_W'(1);
               if (cnt_q == PARM_LEN_W'(1)) begin
                  valid_q         <= 1'b0;
                  done_q[grant_q] <= 1'b1;
                  state_q         <= DONE;
               end
            end
            DONE: state_q <= (|pending_q) ? ARB : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_tx_data   = shift_q[LINE_W-1 -: 8];
   assign o_tx_valid  = valid_q;
   assign o_busy      = (state_q != IDLE);
   assign o_active_ch = grant_q;
   assign o_line_done = done_q;
   assign o_overrun   = overrun_q;

endmodule
